// File: rtl/legv8_pkg.sv
// Shared constants and types for the LEGv8 multicycle main control.
package legv8_pkg;

    localparam int unsigned OPCODE_W = 11;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned PERF_W   = 32;

    // Full 11-bit opcodes
    localparam logic [OPCODE_W-1:0] OP_LDUR = 11'b11111000010;
    localparam logic [OPCODE_W-1:0] OP_STUR = 11'b11111000000;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 11'b10001011000;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 11'b11001011000;
    localparam logic [OPCODE_W-1:0] OP_AND  = 11'b10001010000;
    localparam logic [OPCODE_W-1:0] OP_ORR  = 11'b10101010000;

    // Prefix-matched opcodes (upper bits only)
    localparam logic [7:0] OP_CBZ_PFX = 8'b10110100;
    localparam logic [5:0] OP_B_PFX   = 6'b000101;

    // ALUop encodings consumed by ALU control
    localparam logic [ALUOP_W-1:0] ALUOP_MEM = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_BR  = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_R   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_MEM = 4'd2,
        S_MEM      = 4'd3,
        S_WB_LD    = 4'd4,
        S_EXEC_R   = 4'd5,
        S_WB_R     = 4'd6,
        S_EXEC_BR  = 4'd7,
        S_HALT     = 4'd8
    } ctrl_state_t;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_LDUR = 3'd1,
        CLS_STUR = 3'd2,
        CLS_R    = 3'd3,
        CLS_CBZ  = 3'd4,
        CLS_B    = 3'd5
    } op_class_t;

    // Registered Moore outputs of the control FSM
    typedef struct packed {
        logic               mem_req;
        logic               mem_we;
        logic               reg2loc;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_to_reg;
        logic               reg_write;
        logic               halted;
    } ctrl_out_t;

endpackage

// File: rtl/legv8_opclass_decode.sv
// Combinational opcode classifier used by the control FSM in DECODE.
module legv8_opclass_decode
    import legv8_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output op_class_t           op_class,
    output logic                illegal
);

    // Exact matches first, then the prefix-matched branch forms
    always_comb begin
        op_class = CLS_NONE;
        if (opcode == OP_LDUR) begin
            op_class = CLS_LDUR;
        end else if (opcode == OP_STUR) begin
            op_class = CLS_STUR;
        end else if ((opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_ORR)) begin
            op_class = CLS_R;
        end else if (opcode[OPCODE_W-1 -: 8] == OP_CBZ_PFX) begin
            op_class = CLS_CBZ;
        end else if (opcode[OPCODE_W-1 -: 6] == OP_B_PFX) begin
            op_class = CLS_B;
        end
        illegal = (op_class == CLS_NONE);
    end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// LEGv8 multicycle main control FSM with req/ack unified-memory handshake.
// Optional macro CTRL_PERF_EN adds retired / stall_cycles counters.
module legv8_multicycle_ctrl
    import legv8_pkg::*;
#(
    parameter int unsigned ILLEGAL_HALT = 1
) (
    input  logic                CLK,
    input  logic                Resetb,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                Zero,
    input  logic                mem_ack,
    output logic                mem_req,
    output logic                mem_we,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                PCSrc,
    output logic                Reg2Loc,
    output logic                ALUSrc,
    output logic [ALUOP_W-1:0]  ALUop,
    output logic                MemtoReg,
    output logic                RegWrite,
`ifdef CTRL_PERF_EN
    output logic [PERF_W-1:0]   retired,
    output logic [PERF_W-1:0]   stall_cycles,
`endif
    output logic                halted
);

    ctrl_state_t state_q, state_d;
    op_class_t   cls_q, cls_d, dec_class;
    ctrl_out_t   out_q, out_d;
    logic        dec_illegal;
    logic        fetch_ack, mem_done, br_take;

    legv8_opclass_decode u_decode (
        .opcode   (Opcode),
        .op_class (dec_class),
        .illegal  (dec_illegal)
    );

    // An ack only counts while our own request is up in FETCH or MEM
    assign fetch_ack = (state_q == S_FETCH) && out_q.mem_req && mem_ack;
    assign mem_done  = (state_q == S_MEM)   && out_q.mem_req && mem_ack;
    assign br_take   = (state_q == S_EXEC_BR) && ((cls_q == CLS_B) || Zero);

    // Class is captured from the live decoder only in DECODE
    assign cls_d = (state_q == S_DECODE) ? dec_class : cls_q;

    // State, latched class and output register; reset abandons any request
    always_ff @(posedge CLK or negedge Resetb) begin
        if (!Resetb) begin
            state_q <= S_FETCH;
            cls_q   <= CLS_NONE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            out_q   <= out_d;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (fetch_ack) state_d = S_DECODE;
            S_DECODE: begin
                if (dec_illegal) begin
                    state_d = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;
                end else begin
                    case (dec_class)
                        CLS_LDUR, CLS_STUR: state_d = S_EXEC_MEM;
                        CLS_R:              state_d = S_EXEC_R;
                        default:            state_d = S_EXEC_BR;
                    endcase
                end
            end
            S_EXEC_MEM: state_d = S_MEM;
            S_MEM:      if (mem_done) state_d = (cls_q == CLS_STUR) ? S_FETCH : S_WB_LD;
            S_WB_LD:    state_d = S_FETCH;
            S_EXEC_R:   state_d = S_WB_R;
            S_WB_R:     state_d = S_FETCH;
            S_EXEC_BR:  state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore output decode of the upcoming state, registered so it lines up with state_q
    always_comb begin
        out_d = '0;
        case (state_d)
            S_FETCH:    out_d.mem_req = 1'b1;
            S_EXEC_MEM: begin
                out_d.alu_op  = ALUOP_MEM;
                out_d.alu_src = 1'b1;
                out_d.reg2loc = (cls_d == CLS_STUR);
            end
            S_MEM: begin
                out_d.mem_req = 1'b1;
                out_d.mem_we  = (cls_d == CLS_STUR);
                out_d.reg2loc = (cls_d == CLS_STUR);
            end
            S_WB_LD: begin
                out_d.reg_write  = 1'b1;
                out_d.mem_to_reg = 1'b1;
            end
            S_EXEC_R:   out_d.alu_op = ALUOP_R;
            S_WB_R: begin
                out_d.alu_op    = ALUOP_R;
                out_d.reg_write = 1'b1;
            end
            S_EXEC_BR: begin
                out_d.alu_op  = ALUOP_BR;
                out_d.reg2loc = 1'b1;
            end
            S_HALT:     out_d.halted = 1'b1;
            default:    out_d = '0;
        endcase
    end

    assign mem_req  = out_q.mem_req;
    assign mem_we   = out_q.mem_we;
    assign Reg2Loc  = out_q.reg2loc;
    assign ALUSrc   = out_q.alu_src;
    assign ALUop    = out_q.alu_op;
    assign MemtoReg = out_q.mem_to_reg;
    assign RegWrite = out_q.reg_write;
    assign halted   = out_q.halted;

    // IR/PC strobes must land in the ack / Zero cycle itself, so they qualify the registered state
    assign IRWrite = fetch_ack;
    assign PCWrite = fetch_ack || br_take;
    assign PCSrc   = br_take;

`ifdef CTRL_PERF_EN
    logic [PERF_W-1:0] retired_q, retired_d, stall_q, stall_d;

    // Retire on every return to FETCH; stall on every unacknowledged request cycle
    always_comb begin
        retired_d = retired_q;
        stall_d   = stall_q;
        if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
            retired_d = retired_q + PERF_W'(1);
        end
        if (out_q.mem_req && !mem_ack) begin
            stall_d = stall_q + PERF_W'(1);
        end
    end

    // Performance counter registers
    always_ff @(posedge CLK or negedge Resetb) begin
        if (!Resetb) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    assign retired      = retired_q;
    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Scoreboard bench for legv8_multicycle_ctrl: each driven cycle queues its expected outputs.
module tb_legv8_multicycle_ctrl;

    // Expected-vector bit masks: {req,we,irw,pcw,pcsrc,r2l,alusrc,aluop[1:0],m2r,rw,halt}
    localparam logic [11:0] REQ   = 12'h800;
    localparam logic [11:0] WE    = 12'h400;
    localparam logic [11:0] IRW   = 12'h200;
    localparam logic [11:0] PCW   = 12'h100;
    localparam logic [11:0] PSRC  = 12'h080;
    localparam logic [11:0] R2L   = 12'h040;
    localparam logic [11:0] ASRC  = 12'h020;
    localparam logic [11:0] AOP_R = 12'h010;
    localparam logic [11:0] AOP_B = 12'h008;
    localparam logic [11:0] M2R   = 12'h004;
    localparam logic [11:0] RW    = 12'h002;
    localparam logic [11:0] HLT   = 12'h001;
    localparam logic [11:0] NONE  = 12'h000;

    localparam logic [10:0] T_ADD  = 11'b10001011000;
    localparam logic [10:0] T_LDUR = 11'b11111000010;
    localparam logic [10:0] T_STUR = 11'b11111000000;
    localparam logic [10:0] T_CBZ1 = 11'b10110100101;
    localparam logic [10:0] T_CBZ2 = 11'b10110100000;
    localparam logic [10:0] T_B    = 11'b00010110101;
    localparam logic [10:0] T_ILL  = 11'b11111111111;
    localparam logic [10:0] T_ORR  = 11'b10101010000;
    localparam logic [10:0] T_AND  = 11'b10001010000;

    typedef struct {
        string       name;
        logic [11:0] exp;
    } exp_t;

    logic        CLK, Resetb, Zero, mem_ack;
    logic [10:0] Opcode;
    logic        mem_req, mem_we, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc;
    logic [1:0]  ALUop;
    logic        MemtoReg, RegWrite, halted;
`ifdef CTRL_PERF_EN
    logic [31:0] retired, stall_cycles;
`endif

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    legv8_multicycle_ctrl #(.ILLEGAL_HALT(1)) dut (
        .CLK          (CLK),
        .Resetb       (Resetb),
        .Opcode       (Opcode),
        .Zero         (Zero),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .IRWrite      (IRWrite),
        .PCWrite      (PCWrite),
        .PCSrc        (PCSrc),
        .Reg2Loc      (Reg2Loc),
        .ALUSrc       (ALUSrc),
        .ALUop        (ALUop),
        .MemtoReg     (MemtoReg),
        .RegWrite     (RegWrite),
`ifdef CTRL_PERF_EN
        .retired      (retired),
        .stall_cycles (stall_cycles),
`endif
        .halted       (halted)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Drive one cycle's inputs just after the rising edge and queue that cycle's expected outputs
    task automatic step(input logic rstb, input logic ack, input logic zero,
                        input logic [11:0] exp, input string name);
        @(posedge CLK);
        #1;
        Resetb  = rstb;
        mem_ack = ack;
        Zero    = zero;
        sb_q.push_back('{name, exp});
    endtask

    // Monitor: the DUT presents a Moore output every cycle; compare mid-cycle
    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_tests++;
            if ({mem_req, mem_we, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc,
                 ALUop, MemtoReg, RegWrite, halted} !== mon_e.exp) begin
                n_fail++;
                $display("FAIL %s: got %03h expected %03h at %0t", mon_e.name,
                         {mem_req, mem_we, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc,
                          ALUop, MemtoReg, RegWrite, halted}, mon_e.exp, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        Resetb  = 1'b0;
        mem_ack = 1'b0;
        Zero    = 1'b0;
        Opcode  = '0;

        step(0, 0, 0, NONE, "reset");
        step(1, 0, 0, NONE, "reset_release");

        // ADD, ack on the first FETCH cycle
        Opcode = T_ADD;
        step(1, 1, 0, REQ | IRW | PCW, "add_fetch_ack");
        step(1, 0, 0, NONE,            "add_decode");
        step(1, 0, 0, AOP_R,           "add_exec");
        step(1, 0, 0, AOP_R | RW,      "add_wb");

        // LDUR with three MEM wait cycles
        Opcode = T_LDUR;
        step(1, 1, 0, REQ | IRW | PCW, "ldur_fetch_ack");
        step(1, 0, 0, NONE,            "ldur_decode");
        step(1, 0, 0, ASRC,            "ldur_exec");
        step(1, 0, 0, REQ,             "ldur_mem_w0");
        step(1, 0, 0, REQ,             "ldur_mem_w1");
        step(1, 0, 0, REQ,             "ldur_mem_w2");
        step(1, 1, 0, REQ,             "ldur_mem_ack");
        step(1, 0, 0, M2R | RW,        "ldur_wb");

        // STUR, zero-wait MEM
        Opcode = T_STUR;
        step(1, 1, 0, REQ | IRW | PCW, "stur_fetch_ack");
        step(1, 0, 0, NONE,            "stur_decode");
        step(1, 0, 0, ASRC | R2L,      "stur_exec");
        step(1, 1, 0, REQ | WE | R2L,  "stur_mem_ack");

        // CBZ taken
        Opcode = T_CBZ1;
        step(1, 1, 0, REQ | IRW | PCW,            "cbz1_fetch_ack");
        step(1, 0, 0, NONE,                       "cbz1_decode");
        step(1, 0, 1, AOP_B | R2L | PCW | PSRC,   "cbz1_exec_taken");

        // CBZ not taken
        Opcode = T_CBZ2;
        step(1, 1, 0, REQ | IRW | PCW, "cbz2_fetch_ack");
        step(1, 0, 0, NONE,            "cbz2_decode");
        step(1, 0, 0, AOP_B | R2L,     "cbz2_exec_not_taken");

        // B is unconditional even with Zero low
        Opcode = T_B;
        step(1, 1, 0, REQ | IRW | PCW,          "b_fetch_ack");
        step(1, 0, 0, NONE,                     "b_decode");
        step(1, 0, 0, AOP_B | R2L | PCW | PSRC, "b_exec");

        // Illegal opcode parks in HALT; acks are ignored there
        Opcode = T_ILL;
        step(1, 1, 0, REQ | IRW | PCW, "ill_fetch_ack");
        step(1, 0, 0, NONE,            "ill_decode");
        step(1, 1, 0, HLT,             "halt_0");
        step(1, 1, 0, HLT,             "halt_1");
        step(1, 0, 0, HLT,             "halt_2");
        step(0, 0, 0, NONE,            "halt_reset_low");
        step(1, 1, 0, NONE,            "halt_reset_release_ack_ignored");

        // Reset while STUR waits in MEM
        Opcode = T_STUR;
        step(1, 1, 0, REQ | IRW | PCW, "stur2_fetch_ack");
        step(1, 0, 0, NONE,            "stur2_decode");
        step(1, 0, 0, ASRC | R2L,      "stur2_exec");
        step(1, 0, 0, REQ | WE | R2L,  "stur2_mem_w0");
        step(1, 0, 0, REQ | WE | R2L,  "stur2_mem_w1");
        step(0, 0, 0, NONE,            "mem_reset_low");
`ifdef CTRL_PERF_EN
        @(negedge CLK);
        n_tests++;
        if (retired !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_retired_reset: got %0d expected 0", retired);
        end
        n_tests++;
        if (stall_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_stall_reset: got %0d expected 0", stall_cycles);
        end
`endif
        step(1, 0, 0, NONE,            "mem_reset_release");
        step(1, 0, 0, REQ,             "refetch_no_we");

        // ORR with stray acks outside FETCH/MEM
        Opcode = T_ORR;
        step(1, 1, 0, REQ | IRW | PCW, "orr_fetch_ack");
        step(1, 1, 0, NONE,            "orr_decode_ack_ignored");
        step(1, 1, 0, AOP_R,           "orr_exec_ack_ignored");
        step(1, 1, 0, AOP_R | RW,      "orr_wb_ack_ignored");

        // AND
        Opcode = T_AND;
        step(1, 1, 0, REQ | IRW | PCW, "and_fetch_ack");
        step(1, 0, 0, NONE,            "and_decode");
        step(1, 0, 0, AOP_R,           "and_exec");
        step(1, 0, 0, AOP_R | RW,      "and_wb");
        step(1, 0, 0, REQ,             "and_back_to_fetch");

        @(negedge CLK);
        #1;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
